// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-producer 2-entry result FIFOs feeding one registered
// common-data bus, granted round-robin; rob_clear flushes everything.
module cdb_arbiter #(
    parameter int NREQ  = 3,
    parameter int ROB_W = 4,
    localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  rob_clear,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*ROB_W-1:0] req_rob_id,
    input  logic [NREQ*32-1:0]    req_val,
    output logic [NREQ-1:0]       req_ready,
    output logic                  cdb_valid,
    output logic [ROB_W-1:0]      cdb_rob_id,
    output logic [31:0]           cdb_val,
    output logic [SRC_W-1:0]      cdb_src
);

    logic [ROB_W-1:0] r_fifoId  [NREQ][2];
    logic [31:0]      r_fifoVal [NREQ][2];
    logic [1:0]       r_count   [NREQ];
    logic             r_wrPtr   [NREQ];
    logic             r_rdPtr   [NREQ];
    logic [SRC_W-1:0] r_rrPtr;
    logic             r_cdbValid;
    logic [ROB_W-1:0] r_cdbRobId;
    logic [31:0]      r_cdbVal;
    logic [SRC_W-1:0] r_cdbSrc;

    logic [NREQ-1:0]  w_nonEmpty;
    logic [NREQ-1:0]  w_push;
    logic [NREQ-1:0]  w_pop;
    logic             w_found;
    logic [SRC_W-1:0] w_winner;

    // Ready looks only at the registered count, so a full FIFO stays closed
    // even in the cycle its head is being broadcast.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_nonEmpty[i] = (r_count[i] != 2'd0);
            req_ready[i]  = (r_count[i] != 2'd2) && !rob_clear;
            w_push[i]     = rdy_in && req_valid[i] && req_ready[i];
        end
    end

    // Scanning downward means the last hit is the first non-empty FIFO at or after rr_ptr.
    always_comb begin
        logic [SRC_W-1:0] idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = SRC_W'((int'(r_rrPtr) + k) % NREQ);
            if (w_nonEmpty[idx]) begin
                w_found  = 1'b1;
                w_winner = idx;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            w_pop[i] = w_found && (w_winner == SRC_W'(i));
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NREQ; i++) begin
                r_count[i] <= '0;
                r_wrPtr[i] <= 1'b0;
                r_rdPtr[i] <= 1'b0;
                for (int j = 0; j < 2; j++) begin
                    r_fifoId[i][j]  <= '0;
                    r_fifoVal[i][j] <= '0;
                end
            end
            r_rrPtr    <= '0;
            r_cdbValid <= 1'b0;
            r_cdbRobId <= '0;
            r_cdbVal   <= '0;
            r_cdbSrc   <= '0;
        end else if (rdy_in) begin
            if (rob_clear) begin
                for (int i = 0; i < NREQ; i++) begin
                    r_count[i] <= '0;
                    r_wrPtr[i] <= 1'b0;
                    r_rdPtr[i] <= 1'b0;
                end
                r_rrPtr    <= '0;
                r_cdbValid <= 1'b0;
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (w_push[i]) begin
                        r_fifoId[i][r_wrPtr[i]]  <= req_rob_id[i*ROB_W +: ROB_W];
                        r_fifoVal[i][r_wrPtr[i]] <= req_val[i*32 +: 32];
                        r_wrPtr[i]               <= ~r_wrPtr[i];
                    end
                    if (w_pop[i]) begin
                        r_rdPtr[i] <= ~r_rdPtr[i];
                    end
                    if (w_push[i] && !w_pop[i]) begin
                        r_count[i] <= r_count[i] + 2'd1;
                    end else if (!w_push[i] && w_pop[i]) begin
                        r_count[i] <= r_count[i] - 2'd1;
                    end
                end
                if (w_found) begin
                    r_cdbValid <= 1'b1;
                    r_cdbRobId <= r_fifoId[w_winner][r_rdPtr[w_winner]];
                    r_cdbVal   <= r_fifoVal[w_winner][r_rdPtr[w_winner]];
                    r_cdbSrc   <= w_winner;
                    r_rrPtr    <= (w_winner == SRC_W'(NREQ - 1)) ? '0 : w_winner + 1'b1;
                end else begin
                    r_cdbValid <= 1'b0;
                end
            end
        end
    end

    assign cdb_valid  = r_cdbValid;
    assign cdb_rob_id = r_cdbRobId;
    assign cdb_val    = r_cdbVal;
    assign cdb_src    = r_cdbSrc;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed stimulus against a queue-based reference of the
// round-robin writeback bus, checked every cycle.
module tb_cdb_arbiter;

    localparam int NREQ  = 3;
    localparam int ROB_W = 4;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear;
    logic [2:0]  req_valid;
    logic [11:0] req_rob_id;
    logic [95:0] req_val;
    logic [2:0]  req_ready;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_id;
    logic [31:0] cdb_val;
    logic [1:0]  cdb_src;

    int checks = 0;
    int errors = 0;

    logic [35:0] mq [NREQ][$];
    int          mrr;
    logic        expValid;
    logic [3:0]  expId;
    logic [31:0] expVal;
    logic [1:0]  expSrc;
    int          seqNo [NREQ];
    logic [2:0]  acc;

    cdb_arbiter #(.NREQ(NREQ), .ROB_W(ROB_W)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .rob_clear  (rob_clear),
        .req_valid  (req_valid),
        .req_rob_id (req_rob_id),
        .req_val    (req_val),
        .req_ready  (req_ready),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_val    (cdb_val),
        .cdb_src    (cdb_src)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wipes the reference back to its reset picture.
    function automatic void modelReset();
        for (int i = 0; i < NREQ; i++) mq[i].delete();
        mrr      = 0;
        expValid = 1'b0;
        expId    = '0;
        expVal   = '0;
        expSrc   = '0;
    endfunction

    function automatic void loadPayload();
        for (int i = 0; i < NREQ; i++) begin
            req_rob_id[i*4 +: 4]   = 4'(seqNo[i] + i * 5);
            req_val[i*32 +: 32]    = {8'(i + 1), 24'(seqNo[i])};
        end
    endfunction

    // One clock: drive inputs, check ready, advance the reference, check the bus.
    task automatic applyStimulus(input logic rdy, input logic clr, input logic [2:0] valid,
                                 output logic [2:0] accepted);
        logic [2:0]  expReady;
        logic [35:0] head;
        int          win;
        int          idx;
        bit          found;
        rdy_in    = rdy;
        rob_clear = clr;
        req_valid = valid;
        accepted  = '0;
        #1;
        for (int i = 0; i < NREQ; i++) expReady[i] = (mq[i].size() != 2) && !clr;
        checkOutput("req_ready", 64'(req_ready), 64'(expReady));
        found = 0;
        win   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (mrr + k) % NREQ;
            if (mq[idx].size() != 0) begin
                found = 1;
                win   = idx;
            end
        end
        @(posedge clk_in);
        if (rdy) begin
            if (clr) begin
                for (int i = 0; i < NREQ; i++) mq[i].delete();
                mrr      = 0;
                expValid = 1'b0;
            end else begin
                if (found) begin
                    head     = mq[win].pop_front();
                    expValid = 1'b1;
                    expId    = head[35:32];
                    expVal   = head[31:0];
                    expSrc   = 2'(win);
                    mrr      = (win + 1) % NREQ;
                end else begin
                    expValid = 1'b0;
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (valid[i] && expReady[i]) begin
                        mq[i].push_back({req_rob_id[i*4 +: 4], req_val[i*32 +: 32]});
                        accepted[i] = 1'b1;
                    end
                end
            end
        end
        #1;
        checkOutput("cdb_valid", 64'(cdb_valid), 64'(expValid));
        checkOutput("cdb_rob_id", 64'(cdb_rob_id), 64'(expId));
        checkOutput("cdb_val", 64'(cdb_val), 64'(expVal));
        checkOutput("cdb_src", 64'(cdb_src), 64'(expSrc));
    endtask

    task automatic runCycles(input int n, input logic rdy, input logic [2:0] valid);
        logic [2:0] a;
        for (int c = 0; c < n; c++) begin
            loadPayload();
            applyStimulus(rdy, 1'b0, valid, a);
            for (int i = 0; i < NREQ; i++) if (a[i]) seqNo[i]++;
        end
    endtask

    initial begin
        rst_in     = 1'b1;
        rdy_in     = 1'b1;
        rob_clear  = 1'b0;
        req_valid  = '0;
        req_rob_id = '0;
        req_val    = '0;
        for (int i = 0; i < NREQ; i++) seqNo[i] = 1;
        modelReset();

        repeat (2) @(posedge clk_in);
        #1;
        checkOutput("reset_valid", 64'(cdb_valid), 64'(0));
        checkOutput("reset_rob_id", 64'(cdb_rob_id), 64'(0));
        checkOutput("reset_val", 64'(cdb_val), 64'(0));
        checkOutput("reset_src", 64'(cdb_src), 64'(0));
        checkOutput("reset_ready", 64'(req_ready), 64'(3'b111));
        rst_in = 1'b0;

        $display("[TB] single push from producer 0");
        req_rob_id = 12'h005;
        req_val    = {64'h0, 32'hDEADBEEF};
        applyStimulus(1'b1, 1'b0, 3'b001, acc);
        req_rob_id = '0;
        req_val    = '0;
        applyStimulus(1'b1, 1'b0, 3'b000, acc);
        checkOutput("single_id", 64'(cdb_rob_id), 64'(5));
        checkOutput("single_val", 64'(cdb_val), 64'(32'hDEADBEEF));
        applyStimulus(1'b1, 1'b0, 3'b000, acc);

        $display("[TB] full contention");
        runCycles(12, 1'b1, 3'b111);
        runCycles(6, 1'b1, 3'b000);

        $display("[TB] producer 1 burst against busy neighbours");
        runCycles(4, 1'b1, 3'b101);
        runCycles(3, 1'b1, 3'b010);
        runCycles(8, 1'b1, 3'b000);

        $display("[TB] flush with everything full");
        runCycles(3, 1'b1, 3'b111);
        loadPayload();
        applyStimulus(1'b1, 1'b1, 3'b111, acc);
        runCycles(3, 1'b1, 3'b000);
        runCycles(1, 1'b1, 3'b111);
        runCycles(4, 1'b1, 3'b000);

        $display("[TB] rdy_in stall");
        runCycles(2, 1'b1, 3'b111);
        runCycles(4, 1'b0, 3'b111);
        runCycles(6, 1'b1, 3'b000);

        $display("[TB] asynchronous reset mid-cycle");
        runCycles(2, 1'b1, 3'b111);
        runCycles(1, 1'b1, 3'b000);
        checkOutput("pre_reset_valid", 64'(cdb_valid), 64'(1));
        #2;
        rst_in = 1'b1;
        #1;
        checkOutput("async_valid", 64'(cdb_valid), 64'(0));
        checkOutput("async_ready", 64'(req_ready), 64'(3'b111));
        modelReset();
        #1;
        rst_in = 1'b0;
        runCycles(2, 1'b1, 3'b111);
        runCycles(6, 1'b1, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus writeback arbiter between execution producers (ALU reservation station, load/store buffer, future units) and the reorder buffer. It buffers each producer's results in a private 2-entry FIFO and grants one result per cycle onto a single registered broadcast bus, using round-robin arbitration. The bus is consumed by the ROB write-back port and by RS/LSB operand snooping. A ROB misprediction clear flushes all buffered results.

## Interface
- NREQ, 3, number of producers; producer i uses slice i of every vector port.
- ROB_W, 4, ROB index width.
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- rdy_in  input  1  global ready; when low, all state holds.
- rob_clear  input  1  flush: discard all buffered and in-flight results.
- req_valid  input  NREQ  producer i has a result.
- req_rob_id  input  NREQ*ROB_W  ROB index; producer i at [i*ROB_W +: ROB_W].
- req_val  input  NREQ*32  result value; producer i at [i*32 +: 32].
- req_ready  output  NREQ  producer i's result is accepted this cycle if valid.
- cdb_valid  output  1  broadcast valid (registered).
- cdb_rob_id  output  ROB_W  broadcast ROB index (registered).
- cdb_val  output  32  broadcast value (registered).
- cdb_src  output  $clog2(NREQ)  index of granted producer (registered, debug/verification).

## Operation
- Per producer: 2-entry FIFO (entries {rob_id, val}), 2-bit count, 1-bit rd/wr pointers.
- req_ready[i] = (count[i] != 2) && !rob_clear; depends only on registered count (no pop-through to ready).
- Push i: rdy_in && req_valid[i] && req_ready[i]; entry written at tail, count+1.
- Arbitration (combinational, over FIFO heads with count!=0): search from rr_ptr upward modulo NREQ; first non-empty wins.
- Grant (rdy_in, !rob_clear, some FIFO non-empty): winner's head goes to cdb_rob_id/cdb_val/cdb_src, cdb_valid<=1, winner popped, rr_ptr <= (winner+1) mod NREQ.
- No non-empty FIFO: cdb_valid<=0; cdb_rob_id/cdb_val/cdb_src hold; rr_ptr holds.
- Same FIFO push and pop in one cycle: count unchanged, both pointers advance.
- rob_clear with rdy_in high: all counts and pointers <=0, cdb_valid<=0, rr_ptr<=0; pushes in that cycle are dropped (ready low).
- rdy_in low: no push, no pop, no flush; all registers hold (cdb_valid keeps its value, so consumers must also qualify with rdy_in).
- Ordering: results from one producer appear on the bus in acceptance order; there is no ordering between producers.
- Fairness: with all producers continuously non-empty, each is granted exactly once every NREQ cycles.

## Timing
- Reset (async, rst_in high): cdb_valid=0, cdb_rob_id=0, cdb_val=0, cdb_src=0, rr_ptr=0, all counts=0, so req_ready=all ones once rob_clear is low.
- Latency: result presented and accepted at edge k; earliest bus broadcast registered at edge k+1, visible during cycle k+1 to k+2. That is 1 cycle minimum in FIFO, 2 edges presentation-to-bus.
- Throughput: 1 result per cycle total; sustained 1/NREQ per producer under full contention. Per producer, a full FIFO (2 entries) deasserts ready until a pop edge.
- A broadcast registered at edge k is valid only during the following cycle; a rob_clear sampled at edge k+1 clears cdb_valid at that edge.
- Reset asserted mid-operation: all state cleared immediately, without waiting for a clock edge.

## Test plan
- Reset, then single push producer 0 {rob_id=5, val=0xDEADBEEF} at edge 1 -> cdb_valid=1, rob_id=5, val=0xDEADBEEF, src=0 after edge 2, then cdb_valid=0 after edge 3.
- All three producers push every cycle with ready honoured -> grants rotate 0,1,2,0,1,2; each req_ready toggles so each producer sustains 1/3 rate; no result lost or duplicated (scoreboard).
- Producer 1 pushes 3 results back-to-back while producers 0 and 2 hold FIFOs full -> req_ready[1] low after 2 accepts; producer 1's values appear in push order.
- Fill all FIFOs, assert rob_clear for one cycle with req_valid high -> req_ready=0 that cycle; cdb_valid=0 next cycle; no pre-clear rob_id ever broadcast after the clear; rr_ptr restarts at 0.
- rdy_in low for 4 cycles with pending entries and cdb_valid=1 -> outputs, counts and rr_ptr frozen; arbitration resumes from the same rr_ptr when rdy_in returns.
- Assert rst_in asynchronously between edges while cdb_valid=1 -> cdb_valid falls before the next edge, and all req_ready=1 once rob_clear is low.
